// File: rtl/bcd_scan_display_if.sv
// -----------------------------------------------------------------------------
// bcd_scan_display_if
// Bundles the value-load inputs and the display-drive outputs of
// bcd_scan_display.
//   load   : capture strobe; bcd_in is sampled while high
//   bcd_in : packed BCD {hundreds[11:8], tens[7:4], units[3:0]}
//   sel    : digit enables, active low (bit0 units, bit1 tens, bit2 hundreds)
//   seg    : segments, active low, {dp,g,f,e,d,c,b,a}
//   err    : displayed value contains a nibble greater than 9
// Modports: master = the block supplying values and watching the display,
//           slave  = the display driver itself.
// -----------------------------------------------------------------------------
interface bcd_scan_display_if;
  logic        load;
  logic [11:0] bcd_in;
  logic [2:0]  sel;
  logic [7:0]  seg;
  logic        err;

  modport master (output load, output bcd_in, input sel, input seg, input err);
  modport slave  (input load, input bcd_in, output sel, output seg, output err);
endinterface

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Multiplexed 3-digit common-anode 7-segment driver. A loaded BCD value is
// held in a shadow register and only copied to the displayed value when the
// scan re-enters the units slot, so a frame never mixes old and new digits.
// Each digit slot lasts SCAN_DIV cycles and starts with BLANK_CYC cycles with
// every digit disabled to suppress ghosting.
//
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus_if  : bcd_scan_display_if.slave (load, bcd_in in; sel, seg, err out)
// Parameters:
//   SCAN_DIV  : cycles per digit slot (>= 4 and > BLANK_CYC+1)
//   BLANK_CYC : blank cycles at the start of each slot
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, a zero hundreds digit is blanked, and
//                           the tens digit is blanked when hundreds and tens
//                           are both zero. Units is never blanked.
// -----------------------------------------------------------------------------
module bcd_scan_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bcd_scan_display_if.slave  bus_if
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  typedef enum logic [1:0] {
    SCAN_U = 2'd0,
    SCAN_T = 2'd1,
    SCAN_H = 2'd2
  } scan_state_t;

  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_shadow;
  logic [11:0]      r_display;
  logic             r_pending;
  logic             r_err;
  logic [2:0]       r_sel;
  logic [7:0]       r_seg;
  logic [2:0]       w_sel_next;
  logic [7:0]       w_seg_next;

  logic             w_tick;
  logic             w_commit;
  logic [2:0]       w_shadow_gt9;
  logic [2:0]       w_lz_blank;
  logic [7:0]       w_digit_seg [3];

  // Active-low segment code for one nibble; 10..15 show a dash.
  function automatic logic [7:0] f_seg7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hBF;
    endcase
    return seg;
  endfunction

  assign w_tick   = (r_cnt == CNT_LAST);
  // Commit only on the tick that leaves the hundreds slot for the units slot.
  assign w_commit = w_tick && (r_state == SCAN_H) && r_pending;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign w_shadow_gt9[gi] = (r_shadow[gi*4 +: 4] > 4'd9);
      assign w_digit_seg[gi]  = f_seg7(r_display[gi*4 +: 4]);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A nonzero nibble (including >9) is never blanked, so comparing to zero
  // is enough to keep the dash visible.
  assign w_lz_blank = {(r_display[11:8] == 4'd0), (r_display[11:4] == 8'd0), 1'b0};
`else
  assign w_lz_blank = 3'b000;
`endif

  // Slot prescaler.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow capture and frame commit. The commit reads r_shadow before this
  // cycle's load lands, and a same-cycle load keeps pending set so it goes
  // out with the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_display <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_commit) begin
        r_display <= r_shadow;
        r_err     <= |w_shadow_gt9;
      end
      if (bus_if.load) begin
        r_shadow  <= bus_if.bcd_in;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Scan FSM state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SCAN_U;
      r_sel   <= 3'b111;
      r_seg   <= 8'hFF;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_seg   <= w_seg_next;
    end
  end

  always_comb begin
    logic [2:0] act_sel;
    logic [7:0] act_seg;
    logic       act_blank;
    w_state_next = r_state;
    act_sel      = 3'b111;
    act_seg      = 8'hFF;
    act_blank    = 1'b1;
    case (r_state)
      SCAN_U: begin
        if (w_tick) w_state_next = SCAN_T;
        act_sel   = 3'b110;
        act_seg   = w_digit_seg[0];
        act_blank = w_lz_blank[0];
      end
      SCAN_T: begin
        if (w_tick) w_state_next = SCAN_H;
        act_sel   = 3'b101;
        act_seg   = w_digit_seg[1];
        act_blank = w_lz_blank[1];
      end
      SCAN_H: begin
        if (w_tick) w_state_next = SCAN_U;
        act_sel   = 3'b011;
        act_seg   = w_digit_seg[2];
        act_blank = w_lz_blank[2];
      end
      default: begin
        w_state_next = SCAN_U;
      end
    endcase

    w_sel_next = 3'b111;
    w_seg_next = 8'hFF;
    if (r_cnt >= BLANK_END) begin
      // The digit stays enabled when leading-zero blanked; only its segments go dark.
      w_sel_next = act_sel;
      w_seg_next = act_blank ? 8'hFF : act_seg;
    end
  end

  assign bus_if.sel = r_sel;
  assign bus_if.seg = r_seg;
  assign bus_if.err = r_err;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
// Scoreboard bench for bcd_scan_display with SCAN_DIV=8, BLANK_CYC=2.
// Every load is pushed with the clock edge at which its frame commit is due;
// entries are popped as the edge count reaches them, and sel/seg/err are
// compared every cycle against the slot position and the committed value.
// Honours LEADING_ZERO_BLANK_EN when defined.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 3 * SCAN_DIV;

  typedef struct {
    logic [11:0] bcd;
    int          commit;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bcd_scan_display_if u_if ();

  bcd_scan_display #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus_if  (u_if.slave)
  );

  always #5 clk = ~clk;

  sb_t         sb_q[$];
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          p_edge   = 0;   // rising edges since reset release
  logic [11:0] cur_disp = '0;  // latest value whose commit edge has passed

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, p_edge);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [11:0] d, input int slot);
    logic [3:0] nib;
    nib = d[slot*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2 && nib == 4'd0) return 8'hFF;
    if (slot == 1 && d[11:4] == 8'd0) return 8'hFF;
`endif
    case (nib)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  function automatic logic exp_err(input logic [11:0] d);
    return (d[3:0] > 4'd9) || (d[7:4] > 4'd9) || (d[11:8] > 4'd9);
  endfunction

  // Output registered at edge p shows the state before that edge, so seg uses
  // the value committed strictly before p, while err is already updated at p.
  task automatic check_outputs();
    int          pos;
    int          slot;
    int          c;
    logic [11:0] seg_disp;
    logic [2:0]  esel;
    logic [7:0]  eseg;
    seg_disp = cur_disp;
    while (sb_q.size() > 0 && sb_q[0].commit <= p_edge) begin
      cur_disp = sb_q[0].bcd;
      void'(sb_q.pop_front());
    end
    esel = 3'b111;
    eseg = 8'hFF;
    slot = 0;
    if (p_edge > 0) begin
      pos  = (p_edge - 1) % FRAME;
      slot = pos / SCAN_DIV;
      c    = pos % SCAN_DIV;
      if (c >= BLANK_CYC) begin
        esel = ~(3'b001 << slot);
        eseg = exp_seg(seg_disp, slot);
      end
    end
    check_val($sformatf("sel[s%0d]", slot), 32'(u_if.sel), 32'(esel));
    check_val($sformatf("seg[s%0d,%h]", slot, seg_disp), 32'(u_if.seg), 32'(eseg));
    check_val("err", 32'(u_if.err), 32'(exp_err(cur_disp)));
  endtask

  // One clock: inputs driven at the falling edge, outputs checked at the next.
  task automatic cycle(input logic ld, input logic [11:0] v);
    int commit;
    u_if.load   = ld;
    u_if.bcd_in = v;
    @(posedge clk);
    p_edge++;
    if (ld) begin
      // A load at a commit edge misses that commit and waits a whole frame.
      commit = (p_edge / FRAME + 1) * FRAME;
      sb_q.push_back('{bcd: v, commit: commit});
      $display("[TB] load %h at edge %0d, commit due at edge %0d", v, p_edge, commit);
    end
    @(negedge clk);
    u_if.load = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'h000);
  endtask

  // Idle until the edge count modulo the frame equals target.
  task automatic run_to(input int target);
    for (int i = 0; i < FRAME && (p_edge % FRAME) != target; i++) cycle(1'b0, 12'h000);
  endtask

  initial begin
    u_if.load   = 1'b0;
    u_if.bcd_in = 12'h000;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Free run after reset: 000 on every digit, err low.
    idle(48);

    // Load mid-hundreds slot: current frame keeps 000, next shows 705.
    run_to(18);
    cycle(1'b1, 12'h705);
    idle(48);

    // Two loads in one frame: last one wins, 123 never shown.
    run_to(2);
    cycle(1'b1, 12'h123);
    idle(5);
    cycle(1'b1, 12'h456);
    idle(48);

    // Load just before a commit edge, then one exactly on the commit edge.
    run_to(22);
    cycle(1'b1, 12'h321);
    cycle(1'b1, 12'h654);
    idle(48);

    // Nibble > 9: dash on tens and err set, then cleared by a clean value.
    cycle(1'b1, 12'h1A3);
    idle(48);
    cycle(1'b1, 12'h042);
    idle(48);

    // Leading-zero cases.
    cycle(1'b1, 12'h007);
    idle(48);
    cycle(1'b1, 12'h000);
    idle(48);

    // Get err high again so the reset check below has something to clear.
    cycle(1'b1, 12'hB09);
    idle(48);

    // Asynchronous reset mid-slot, 3 cycles after a load.
    run_to(1);
    cycle(1'b1, 12'h999);
    idle(3);
    rst_n = 1'b0;
    #1;
    check_val("rst_sel", 32'(u_if.sel), 32'(3'b111));
    check_val("rst_seg", 32'(u_if.seg), 32'(8'hFF));
    check_val("rst_err", 32'(u_if.err), 32'(1'b0));
    sb_q.delete();
    cur_disp = '0;
    p_edge   = 0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle(72);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
